// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM states, frame length and parity helper.
// UART_TX_PARITY_EN adds an even-parity bit and the PARITY state (11-bit frame).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered count and full/empty flags; show-ahead read.
// A write while full is dropped even if a read happens on the same edge.
module uart_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       rd_en,
  output logic [7:0] rdata_c,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned CW    = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wr_ok;
  logic          rd_ok;

  always_comb begin
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + CW'(1);
      2'b01:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  assign rdata_c = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at AW bits; flags track the next count so they stay registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) rptr <= rptr + AW'(1);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop framing FSM.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned FIFO_AW          = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] sdata,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       ovf
);

  localparam int unsigned BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int unsigned TW       = $clog2(BIT_CLKS);
  localparam int unsigned BCW      = $clog2(DATA_BITS);

  state_t         state_q;
  state_t         state_d;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic [BCW-1:0] bit_q;
  logic [BCW-1:0] bit_d;
  logic [7:0]     shreg_q;
  logic [7:0]     shreg_d;
  logic           txd_d;
  logic           pop_c;
  logic           bit_done_c;
  logic           fifo_full;
  logic           fifo_empty;
  logic [7:0]     fifo_rdata_c;
`ifdef UART_TX_PARITY_EN
  logic           par_q;
  logic           par_d;
`endif

  uart_tx_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (tx_start),
    .wdata   (sdata),
    .rd_en   (pop_c),
    .rdata_c (fifo_rdata_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tx_ready   = !fifo_full;
  assign tx_busy    = (state_q != IDLE) || !fifo_empty;
  assign bit_done_c = (timer_q == TW'(BIT_CLKS - 1));

  // Next-state, shifter and line-level logic; txd is the registered image of the next state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop_c   = 1'b0;
    txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (bit_done_c) timer_d = '0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          shreg_d = fifo_rdata_c;
`ifdef UART_TX_PARITY_EN
          par_d   = even_parity(fifo_rdata_c);
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_done_c) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_done_c) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done_c) state_d = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more bytes are queued.
        if (bit_done_c) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            shreg_d = fifo_rdata_c;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(fifo_rdata_c);
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd     <= 1'b1;
      ovf     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd     <= txd_d;
      ovf     <= ovf || (tx_start && fifo_full);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: serial monitor decodes frames against a byte scoreboard.
// Honours UART_TX_PARITY_EN for frame length and parity-bit checks.
module tb_uart_tx_buf;

  localparam int unsigned CPH = 30;
  localparam int unsigned AW  = 2;
  localparam int unsigned BIT = 2 * CPH;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FR = BIT * NB;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] sdata    = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic       ovf;

  uart_tx_buf #(
    .CLK_PER_HALF_BIT (CPH),
    .FIFO_AW          (AW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .sdata    (sdata),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vectors = 0;
  int          errors  = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int unsigned frames = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mwait(input int n, inout bit ab);
    repeat (n) begin
      if (!ab) begin
        @(negedge clk);
        if (rstn !== 1'b1) ab = 1'b1;
      end
    end
  endtask

  // Line monitor: samples mid-bit, drops any frame cut short by reset.
  initial begin : mon
    bit          ab;
    logic [7:0]  b;
    logic [7:0]  e;
    logic        stp;
    int unsigned st;
`ifdef UART_TX_PARITY_EN
    logic        p;
`endif
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        ab = 1'b0;
        st = cyc;
        b  = '0;
        mwait(30, ab);
        if (!ab) chk("start_bit", txd, 0);
        for (int j = 0; j < 8; j++) begin
          mwait(BIT, ab);
          b[j] = txd;
        end
`ifdef UART_TX_PARITY_EN
        mwait(BIT, ab);
        p = txd;
`endif
        mwait(BIT, ab);
        stp = txd;
        if (!ab) begin
          chk("frame_expected", (exp_q.size() != 0), 1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          chk("rx_byte", b, e);
`ifdef UART_TX_PARITY_EN
          chk("parity_bit", p, ^e);
`endif
          chk("stop_bit", stp, 1);
          start_q.push_back(st);
          frames++;
        end
      end
    end
  end

  task automatic wr(input logic [7:0] b, input logic acc);
    @(negedge clk);
    chk($sformatf("ready_at_write_%02h", b), tx_ready, acc);
    tx_start = 1'b1;
    sdata    = b;
    if (acc) exp_q.push_back(b);
  endtask

  task automatic wr_end();
    @(negedge clk);
    tx_start = 1'b0;
    sdata    = 8'($urandom);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned took;
    took = 0;
    while (tx_busy !== 1'b0 && took < budget) begin
      @(posedge clk);
      #1;
      took++;
    end
    chk("idle_within_budget", tx_busy, 0);
  endtask

  initial begin : watchdog
    #900000;
    errors++;
    $display("FAIL watchdog: simulation stuck, observed no completion, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [10:0] fb;
    logic [7:0]  aa;
    int unsigned t0;
    int unsigned p0;
    int unsigned f0;
    int unsigned lows;
    int          n;

    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovf", ovf, 0);

    // Single 0xAA frame, written on the first edge after reset release.
    aa = 8'hAA;
`ifdef UART_TX_PARITY_EN
    fb = {1'b1, ^aa, aa, 1'b0};
`else
    fb = {1'b0, 1'b1, aa, 1'b0};
`endif
    @(negedge clk);
    rstn     = 1'b1;
    tx_start = 1'b1;
    sdata    = aa;
    exp_q.push_back(aa);
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    sdata    = 8'($urandom);
    chk("aa_edge_n_txd", txd, 1);
    chk("aa_edge_n_busy", tx_busy, 1);
    for (int k = 0; k < int'(NB); k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("aa_bit%0d_first", k), txd, fb[k]);
      repeat (BIT - 1) @(posedge clk);
      #1;
      chk($sformatf("aa_bit%0d_last", k), txd, fb[k]);
    end
    @(posedge clk);
    #1;
    chk("aa_busy_end", tx_busy, 0);
    chk("aa_idle_txd", txd, 1);

    // Three back-to-back bytes.
    f0 = frames;
    wr(8'h54, 1'b1);
    t0 = cyc + 1;
    wr(8'h68, 1'b1);
    wr(8'h65, 1'b1);
    wr_end();
    wait_idle(3 * FR + 100);
    chk("burst_len", cyc - t0, 3 * FR + 1);
    chk("burst_frames", frames - f0, 3);
    n = start_q.size();
    chk("burst_gap12", start_q[n-2] - start_q[n-3], FR);
    chk("burst_gap23", start_q[n-1] - start_q[n-2], FR);

    // Six writes into a depth-4 FIFO: one popped, four queued, sixth dropped.
    chk("ovf_clear", ovf, 0);
    f0 = frames;
    wr(8'h10, 1'b1);
    wr(8'h11, 1'b1);
    wr(8'h12, 1'b1);
    wr(8'h13, 1'b1);
    wr(8'h14, 1'b1);
    wr(8'h15, 1'b0);
    wr_end();
    chk("ovf_set", ovf, 1);
    wait_idle(5 * FR + 100);
    chk("ovf_frames", frames - f0, 5);
    chk("ovf_queue_drained", exp_q.size(), 0);
    chk("ovf_sticky", ovf, 1);

    // Reset during data bit 3 of 0xFF.
    wr(8'hFF, 1'b1);
    p0 = cyc + 2;
    wr_end();
    while (cyc < p0 + BIT + 3 * BIT + 30) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", tx_busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_ovf", ovf, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    lows = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) lows++;
    end
    chk("no_resume", lows, 0);
    chk("post_rst_busy", tx_busy, 0);
    f0 = frames;
    wr(8'h01, 1'b1);
    wr_end();
    wait_idle(FR + 50);
    chk("post_rst_frames", frames - f0, 1);

    // Full FIFO with a pop on the same edge as a write attempt.
    f0 = frames;
    wr(8'h20, 1'b1);
    p0 = cyc + 2;
    wr(8'h21, 1'b1);
    wr(8'h22, 1'b1);
    wr(8'h23, 1'b1);
    wr(8'h24, 1'b1);
    wr_end();
    while (cyc < p0 + FR - 1) begin
      @(posedge clk);
      #1;
    end
    chk("full_ovf_before", ovf, 0);
    wr(8'h25, 1'b0);
    wr_end();
    chk("full_pop_ready", tx_ready, 1);
    chk("full_pop_ovf", ovf, 1);
    chk("full_pop_txd", txd, 0);
    wait_idle(5 * FR + 100);
    chk("full_pop_frames", frames - f0, 5);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 has odd weight, 0x03 even.
    wr(8'h07, 1'b1);
    t0 = cyc + 1;
    wr_end();
    wait_idle(FR + 50);
    chk("par07_len", cyc - t0, FR + 1);
    wr(8'h03, 1'b1);
    t0 = cyc + 1;
    wr_end();
    wait_idle(FR + 50);
    chk("par03_len", cyc - t0, FR + 1);
`endif

    repeat (BIT) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
